csr_trap_ctrl: RTL and testbench

Trap and return sequencer for the machine-mode CSR file. It sits between the writeback stage and the CSR file's single write port. On a trap it serialises the CSR updates (mepc, mcause, mtval, mstatus) over successive cycles while stalling the pipeline, then redirects fetch to the trap vector. It also forwards ordinary CSR-instruction writes and mret, and issues the return redirect.

---
 rtl/csr_trap_ctrl_if.sv | 38 +++
 rtl/csr_trap_ctrl.sv | 122 ++++++++++++
 tb/tb_csr_trap_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_trap_ctrl_if.sv
// Bundle of trap/mret/CSR-write requests, CSR read-back and the sequencer's outputs.
// slave is the sequencer side, master is the pipeline/CSR-file side.
interface csr_trap_ctrl_if;
    logic        trap_valid;
    logic [63:0] trap_pc;
    logic [63:0] trap_cause;
    logic [63:0] trap_tval;
    logic        is_mret;
    logic        ins_wvalid;
    logic [11:0] ins_wa;
    logic [63:0] ins_wd;
    logic [63:0] mstatus_i;
    logic [63:0] mtvec_i;
    logic [63:0] mepc_i;
    logic        csr_wvalid;
    logic [11:0] csr_wa;
    logic [63:0] csr_wd;
    logic        csr_is_mret;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    modport slave (
        input  trap_valid, trap_pc, trap_cause, trap_tval,
        input  is_mret, ins_wvalid, ins_wa, ins_wd,
        input  mstatus_i, mtvec_i, mepc_i,
        output csr_wvalid, csr_wa, csr_wd, csr_is_mret,
        output stall, redirect_valid, redirect_pc
    );

    modport master (
        output trap_valid, trap_pc, trap_cause, trap_tval,
        output is_mret, ins_wvalid, ins_wa, ins_wd,
        output mstatus_i, mtvec_i, mepc_i,
        input  csr_wvalid, csr_wa, csr_wd, csr_is_mret,
        input  stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Trap/return sequencer: serialises mepc/mcause/mtval/mstatus writes on a trap,
// forwards CSR-instruction writes and mret, and issues the fetch redirect.
module csr_trap_ctrl (
    input  logic           clk,
    input  logic           reset,
    csr_trap_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, T_REDIR, R_REDIR
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_cause;
    logic [63:0] r_tval;
    logic [63:0] r_mepc;
    logic [63:0] r_target;

    logic [63:0] w_base;
    logic [63:0] w_vec_target;
    logic [63:0] w_mstatus_new;

    assign w_base = {bus.mtvec_i[63:2], 2'b00};
    // Vectored mode only offsets interrupts; the shift truncates cause[62] away.
    assign w_vec_target = (bus.mtvec_i[1:0] == 2'b01 && r_cause[63])
                        ? w_base + {r_cause[61:0], 2'b00} : w_base;

    always_comb begin
        w_mstatus_new        = bus.mstatus_i;
        w_mstatus_new[7]     = bus.mstatus_i[3];
        w_mstatus_new[3]     = 1'b0;
        w_mstatus_new[12:11] = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_cause  <= '0;
            r_tval   <= '0;
            r_mepc   <= '0;
            r_target <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.trap_valid) begin
                        r_pc    <= bus.trap_pc;
                        r_cause <= bus.trap_cause;
                        r_tval  <= bus.trap_tval;
                        r_state <= W_MEPC;
                    end else if (bus.is_mret) begin
                        r_mepc  <= bus.mepc_i;
                        r_state <= R_REDIR;
                    end
                end
                W_MEPC:    r_state <= W_MCAUSE;
                W_MCAUSE:  r_state <= W_MTVAL;
                W_MTVAL:   r_state <= W_MSTATUS;
                W_MSTATUS: begin
                    r_target <= w_vec_target;
                    r_state  <= T_REDIR;
                end
                T_REDIR:   r_state <= IDLE;
                R_REDIR:   r_state <= IDLE;
                default:   r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.csr_wvalid     = 1'b0;
        bus.csr_wa         = '0;
        bus.csr_wd         = '0;
        bus.csr_is_mret    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        case (r_state)
            IDLE: begin
                if (!bus.trap_valid) begin
                    if (bus.is_mret) begin
                        bus.csr_is_mret = 1'b1;
                    end else if (bus.ins_wvalid) begin
                        bus.csr_wvalid = 1'b1;
                        bus.csr_wa     = bus.ins_wa;
                        bus.csr_wd     = bus.ins_wd;
                    end
                end
            end
            W_MEPC: begin
                bus.csr_wvalid = 1'b1;
                bus.csr_wa     = 12'h341;
                bus.csr_wd     = r_pc;
            end
            W_MCAUSE: begin
                bus.csr_wvalid = 1'b1;
                bus.csr_wa     = 12'h342;
                bus.csr_wd     = r_cause;
            end
            W_MTVAL: begin
                bus.csr_wvalid = 1'b1;
                bus.csr_wa     = 12'h343;
                bus.csr_wd     = r_tval;
            end
            W_MSTATUS: begin
                bus.csr_wvalid = 1'b1;
                bus.csr_wa     = 12'h300;
                bus.csr_wd     = w_mstatus_new;
            end
            T_REDIR: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = r_target;
            end
            R_REDIR: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = r_mepc;
            end
            default: ;
        endcase
    end

    assign bus.stall = bus.trap_valid | bus.is_mret | (r_state != IDLE);
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed and randomized traps, mrets and
// CSR writes compared cycle by cycle against a behavioural model of the sequencer.
module tb_csr_trap_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    csr_trap_ctrl_if bus();

    csr_trap_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Observed outputs packed {wvalid, wa, wd, stall, is_mret, redirect_valid, redirect_pc}.
    function automatic logic [143:0] obs();
        return {bus.csr_wvalid, bus.csr_wa, bus.csr_wd, bus.stall, bus.csr_is_mret,
                bus.redirect_valid, bus.redirect_pc};
    endfunction

    function automatic logic [143:0] expv(input logic wv, input logic [11:0] wa,
                                          input logic [63:0] wd, input logic st,
                                          input logic mr, input logic rv,
                                          input logic [63:0] rp);
        return {wv, wa, wd, st, mr, rv, rp};
    endfunction

    // Model: trap entry mstatus (MIE->MPIE, MIE cleared, MPP=M).
    function automatic logic [63:0] model_mstatus(input logic [63:0] m);
        logic [63:0] r;
        r = m & ~64'h0000_0000_0000_1888;
        if ((m & 64'h8) != 0) r = r | 64'h80;
        return r | 64'h1800;
    endfunction

    // Model: trap vector, vectored mode offsets interrupts by 4*cause code.
    function automatic logic [63:0] model_target(input logic [63:0] mtvec, input logic [63:0] cause);
        logic [63:0] base;
        base = mtvec - (mtvec % 4);
        if ((mtvec % 4) == 1 && cause >= 64'h8000_0000_0000_0000)
            return base + (cause - 64'h8000_0000_0000_0000) * 4;
        return base;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.trap_valid = 1'b0;
        bus.is_mret    = 1'b0;
        bus.ins_wvalid = 1'b0;
        bus.trap_pc    = '0;
        bus.trap_cause = '0;
        bus.trap_tval  = '0;
        bus.ins_wa     = '0;
        bus.ins_wd     = '0;
    endtask

    task automatic noise_inputs();
        bus.trap_valid = 1'($urandom);
        bus.is_mret    = 1'($urandom);
        bus.ins_wvalid = 1'($urandom);
        bus.trap_pc    = {$urandom, $urandom};
        bus.trap_cause = {$urandom, $urandom};
        bus.ins_wa     = 12'($urandom);
        bus.ins_wd     = {$urandom, $urandom};
    endtask

    task automatic check_quiet(input string name);
        @(negedge clk);
        n_total++;
        if (obs() !== expv(0, 0, 0, 0, 0, 0, 0))
            $display("FAIL %s: got %h expected %h", name, obs(), expv(0, 0, 0, 0, 0, 0, 0));
        else n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.mstatus_i = '0;
        bus.mtvec_i   = '0;
        bus.mepc_i    = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_quiet("reset_outputs");
        step();
        check_quiet("reset_idle");
    endtask

    task automatic run_ins(input logic [11:0] wa, input logic [63:0] wd, input string name);
        step();
        idle_inputs();
        bus.ins_wvalid = 1'b1;
        bus.ins_wa     = wa;
        bus.ins_wd     = wd;
        @(negedge clk);
        n_total++;
        if (obs() !== expv(1, wa, wd, 0, 0, 0, 0))
            $display("FAIL %s: got %h expected %h", name, obs(), expv(1, wa, wd, 0, 0, 0, 0));
        else n_pass++;
    endtask

    // Trap accepted at T; checks T..T+5. Inputs are left noisy on return.
    task automatic run_trap(input logic [63:0] pc, input logic [63:0] cause,
                            input logic [63:0] tval, input logic [63:0] ms,
                            input logic [63:0] mtv, input bit all_same, input string name);
        logic [11:0] ea[4];
        logic [63:0] ed[4];
        logic [63:0] tgt;
        ea[0] = 12'h341; ed[0] = pc;
        ea[1] = 12'h342; ed[1] = cause;
        ea[2] = 12'h343; ed[2] = tval;
        ea[3] = 12'h300; ed[3] = model_mstatus(ms);
        tgt = model_target(mtv, cause);
        step();
        idle_inputs();
        bus.trap_valid = 1'b1;
        bus.trap_pc    = pc;
        bus.trap_cause = cause;
        bus.trap_tval  = tval;
        bus.mstatus_i  = ms;
        bus.mtvec_i    = mtv;
        if (all_same) begin
            bus.is_mret    = 1'b1;
            bus.ins_wvalid = 1'b1;
            bus.ins_wa     = 12'h305;
            bus.ins_wd     = 64'h1234;
        end
        @(negedge clk);
        n_total++;
        if (obs() !== expv(0, 0, 0, 1, 0, 0, 0))
            $display("FAIL %s_accept: got %h expected %h", name, obs(), expv(0, 0, 0, 1, 0, 0, 0));
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            step();
            noise_inputs();
            @(negedge clk);
            n_total++;
            if (obs() !== expv(1, ea[k], ed[k], 1, 0, 0, 0))
                $display("FAIL %s_write%0d: got %h expected %h", name, k, obs(), expv(1, ea[k], ed[k], 1, 0, 0, 0));
            else n_pass++;
        end
        step();
        noise_inputs();
        @(negedge clk);
        n_total++;
        if (obs() !== expv(0, 0, 0, 1, 0, 1, tgt))
            $display("FAIL %s_redirect: got %h expected %h", name, obs(), expv(0, 0, 0, 1, 0, 1, tgt));
        else n_pass++;
    endtask

    // mret at T with a same-cycle (dropped) ins write; checks T and T+1.
    task automatic run_mret(input logic [63:0] mepc, input string name);
        step();
        idle_inputs();
        bus.is_mret    = 1'b1;
        bus.ins_wvalid = 1'b1;
        bus.ins_wa     = 12'h341;
        bus.ins_wd     = 64'h5555;
        bus.mepc_i     = mepc;
        @(negedge clk);
        n_total++;
        if (obs() !== expv(0, 0, 0, 1, 1, 0, 0))
            $display("FAIL %s_pulse: got %h expected %h", name, obs(), expv(0, 0, 0, 1, 1, 0, 0));
        else n_pass++;
        step();
        noise_inputs();
        bus.mepc_i = ~mepc;
        @(negedge clk);
        n_total++;
        if (obs() !== expv(0, 0, 0, 1, 0, 1, mepc))
            $display("FAIL %s_redirect: got %h expected %h", name, obs(), expv(0, 0, 0, 1, 0, 1, mepc));
        else n_pass++;
    endtask

    task automatic test_ins_write();
        run_ins(12'h340, 64'hABCD, "ins_write");
        for (int i = 0; i < 4; i++) run_ins(12'($urandom), {$urandom, $urandom}, "ins_write_rand");
    endtask

    task automatic test_trap();
        run_trap(64'h8000_0010, 64'd2, 64'hDEAD, 64'h8, 64'h8000_0100, 0, "trap_basic");
        step();
        idle_inputs();
        check_quiet("trap_done");
    endtask

    task automatic test_vectored();
        run_trap(64'h8000_0020, 64'h8000_0000_0000_0007, 64'h0, 64'h0, 64'h8000_0101, 0, "vec_irq");
        step();
        idle_inputs();
        check_quiet("vec_irq_done");
        run_trap(64'h8000_0030, 64'd5, 64'h44, 64'h1888, 64'h8000_0101, 0, "vec_exc");
        step();
        idle_inputs();
        check_quiet("vec_exc_done");
    endtask

    task automatic test_mret();
        run_mret(64'h8000_0044, "mret");
        step();
        idle_inputs();
        check_quiet("mret_done");
    endtask

    task automatic test_same_cycle();
        run_trap(64'h8000_0050, 64'd11, 64'h77, 64'hA, 64'h8000_0200, 1, "same_cycle");
        step();
        idle_inputs();
        check_quiet("same_cycle_done");
    endtask

    task automatic test_reset_mid_trap();
        step();
        idle_inputs();
        bus.trap_valid = 1'b1;
        bus.trap_pc    = 64'h8000_0060;
        bus.trap_cause = 64'd3;
        bus.trap_tval  = 64'h99;
        bus.mtvec_i    = 64'h8000_0300;
        step();
        idle_inputs();
        @(negedge clk);
        n_total++;
        if (obs() !== expv(1, 12'h341, 64'h8000_0060, 1, 0, 0, 0))
            $display("FAIL rst_mid_mepc: got %h expected %h", obs(), expv(1, 12'h341, 64'h8000_0060, 1, 0, 0, 0));
        else n_pass++;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_quiet("rst_mid_abandon");
            step();
        end
    endtask

    task automatic test_back_to_back();
        run_trap(64'h8000_0070, 64'd1, 64'h1, 64'h0, 64'h8000_0400, 0, "b2b_first");
        run_trap(64'h8000_0080, 64'h8000_0000_0000_000B, 64'h2, 64'h8, 64'h8000_0401, 0, "b2b_second");
        step();
        idle_inputs();
        check_quiet("b2b_done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int unsigned op;
            op = $urandom_range(0, 2);
            if (op == 0)
                run_trap({$urandom, $urandom}, {1'($urandom), 55'd0, 8'($urandom)},
                         {$urandom, $urandom}, {$urandom, $urandom},
                         {$urandom, $urandom}, 1'($urandom), "rand_trap");
            else if (op == 1)
                run_mret({$urandom, $urandom}, "rand_mret");
            else
                run_ins(12'($urandom), {$urandom, $urandom}, "rand_ins");
        end
        step();
        idle_inputs();
        check_quiet("rand_done");
    endtask

    initial begin
        test_reset();
        test_ins_write();
        test_trap();
        test_vectored();
        test_mret();
        test_same_cycle();
        test_reset_mid_trap();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
